// File: rtl/dnn_seq_pkg.sv
// Shared state type, default widths and sizing helpers for the DNN input sequencer.
package dnn_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        ISSUE,
        WAIT
    } seq_state_t;

    localparam int DATA_W_DEF = 16;
    localparam int CORE_IN_W  = 2 * DATA_W_DEF;

    // Width of a counter that must be able to hold the value cyc itself.
    function automatic int tmo_cnt_w(input int cyc);
        return (cyc < 2) ? 1 : $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/dnn_res_fifo.sv
// Result FIFO between the inference core and the output stream; count feeds the launch credit.
module dnn_res_fifo
    import dnn_seq_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int CNT_W  = AW + 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so push-while-full is accepted.
    assign do_push = push & (~full | do_pop);

    // NOTE: storage is deliberately left out of reset; stale entries are unreachable
    // because the read side is masked whenever the FIFO is empty.
    always_ff @(posedge ap_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state is written with <= only; combinational logic uses = only.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dnn_input_sequencer.sv
// Pairs 16-bit features into core launches and streams core results out through a FIFO.
// Build option: define DNN_TIMEOUT_EN to add a watchdog on the WAIT state.
module dnn_input_sequencer
    import dnn_seq_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int RES_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                core_start,
    output logic [2*DATA_W-1:0] core_in,
    output logic                core_in_vld,
    input  logic [DATA_W-1:0]   core_out,
    input  logic                core_out_vld,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                busy,
    output logic                timeout_err
);

    localparam int CNT_W = $clog2(RES_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    if (RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RES_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    seq_state_t          state_q;
    seq_state_t          state_d;
    logic [2*DATA_W-1:0] core_in_q;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                in_flight;
    logic                credit_ok;
    logic                accept;
    logic                tmo_fire;

    // Credit = free slots minus the result still owed by the core.
    assign in_flight = (state_q == ISSUE) || (state_q == WAIT);
    assign credit_ok = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, in_flight}) < SUM_W'(RES_DEPTH);

    // Gated by ap_rst so s_ready is already low during reset, not only after it.
    assign s_ready = !ap_rst && (state_q == IDLE || state_q == LO) && credit_ok;
    assign accept  = s_valid && s_ready;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path infers a latch.
        state_d   = state_q;
        fifo_push = 1'b0;
        case (state_q)
            IDLE:    if (accept) state_d = LO;
            LO:      if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (core_out_vld) begin
                    fifo_push = 1'b1;
                    state_d   = IDLE;
                end else if (tmo_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // core_in holds the last complete pair until the next one overwrites it.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            core_in_q <= '0;
        end else if (accept && state_q == IDLE) begin
            core_in_q[DATA_W-1:0] <= s_data;
        end else if (accept && state_q == LO) begin
            core_in_q[2*DATA_W-1:DATA_W] <= s_data;
        end
    end

`ifdef DNN_TIMEOUT_EN
    localparam int TMO_W = tmo_cnt_w(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_q;

    // Counts from the launch cycle so the flag appears TIMEOUT_CYC cycles after core_start.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (in_flight) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            else           tmo_cnt_q <= '0;
            if (tmo_fire)  timeout_q <= 1'b1;
        end
    end

    assign tmo_fire    = (state_q == WAIT) && !core_out_vld
                         && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
    assign timeout_err = timeout_q;
`else
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    dnn_res_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RES_DEPTH)
    ) u_res_fifo (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .push      (fifo_push),
        .push_data (core_out),
        .pop       (fifo_pop),
        .pop_data  (m_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign fifo_pop    = m_valid && m_ready;
    assign m_valid     = !fifo_empty;
    assign core_start  = (state_q == ISSUE);
    assign core_in_vld = (state_q == ISSUE);
    assign core_in     = core_in_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dnn_input_sequencer.sv
// Self-checking bench: fixed vectors, corner sequences and random traffic against a pair-level model.
module tb_dnn_input_sequencer;

    localparam int DATA_W      = 16;
    localparam int RES_DEPTH   = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int CORE_LAT    = 12;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        core_start;
    logic [31:0] core_in;
    logic        core_in_vld;
    logic [15:0] core_out;
    logic        core_out_vld;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        timeout_err;

    dnn_input_sequencer #(
        .DATA_W      (DATA_W),
        .RES_DEPTH   (RES_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .core_start   (core_start),
        .core_in      (core_in),
        .core_in_vld  (core_in_vld),
        .core_out     (core_out),
        .core_out_vld (core_out_vld),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [15:0] x0;
        logic [15:0] x1;
        logic [31:0] exp_in;
        logic [15:0] exp_y;
    } vec_t;

    vec_t tbl [6];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Core model and reference state
    int          pend_cnt      = 0;
    logic [15:0] pend_data     = '0;
    bit          pend_stale    = 0;
    bit          core_silent   = 0;
    bit          spur_pending  = 0;
    logic [15:0] spur_data     = '0;
    logic [15:0] feat_q [$];
    logic [15:0] exp_q [$];
    logic [31:0] exp_core_in   = '0;
    bit          inflight      = 0;
    bit          exp_tmo       = 0;
    int          tmo_at        = -1;
    int          first_tmo_cyc = -1;
    int          last_pair_cyc = -10;
    int          last_launch   = -10;
    int          genuine_cyc   = -10;
    int          pop_total     = 0;
    bit          acc_seen      = 0;
    bit          pop_seen      = 0;
    logic [15:0] last_pop      = '0;

    function automatic logic [15:0] ref_y(input logic [15:0] x0, input logic [15:0] x1);
        int a;
        int b;
        a = -288 * int'($signed(x0));
        b = 304 * int'($signed(x1));
        return 16'((a >>> 10) + (b >>> 10) + 157);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_bound(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // One clock: observe and score at the falling edge, then drive the core model after the rising edge.
    task automatic tick();
        @(negedge ap_clk);
        acc_seen = 0;
        pop_seen = 0;
        if (tmo_at == cyc) begin
            exp_tmo  = 1;
            inflight = 0;
            if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
            tmo_at = -1;
        end
        if (timeout_err && first_tmo_cyc < 0) first_tmo_cyc = cyc;
        check("s_ready", 64'(s_ready), 64'(!ap_rst && !inflight && exp_q.size() < RES_DEPTH));
        check("timeout_err", 64'(timeout_err), 64'(exp_tmo));
        check("core_start", 64'(core_start), 64'(cyc == last_pair_cyc + 1));
        check("core_in_vld", 64'(core_in_vld), 64'(cyc == last_pair_cyc + 1));
        if (genuine_cyc == cyc - 1) check("m_valid_latency", 64'(m_valid), 64'd1);
        if (core_out_vld && genuine_cyc == cyc) inflight = 0;
        if (core_start) begin
            check("core_in", 64'(core_in), 64'(exp_core_in));
            pend_cnt    = CORE_LAT;
            pend_data   = ref_y(core_in[15:0], core_in[31:16]);
            pend_stale  = 0;
            last_launch = cyc;
`ifdef DNN_TIMEOUT_EN
            if (core_silent) tmo_at = cyc + TIMEOUT_CYC;
`endif
        end
        if (m_valid && m_ready) begin
            pop_seen = 1;
            last_pop = m_data;
            pop_total++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: actual 0x%0h required none (cycle %0d)", m_data, cyc);
            end else begin
                check("result", 64'(m_data), 64'(exp_q.pop_front()));
            end
        end
        if (s_valid && s_ready) begin
            acc_seen = 1;
            feat_q.push_back(s_data);
            if (feat_q.size() == 2) begin
                exp_q.push_back(ref_y(feat_q[0], feat_q[1]));
                exp_core_in   = {feat_q[1], feat_q[0]};
                last_pair_cyc = cyc;
                inflight      = 1;
                feat_q.delete();
            end
        end
        @(posedge ap_clk);
        #1;
        cyc++;
        core_out_vld = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0 && !core_silent) begin
                core_out_vld = 1'b1;
                core_out     = pend_data;
                if (!pend_stale) genuine_cyc = cyc;
            end
        end else if (spur_pending) begin
            core_out_vld = 1'b1;
            core_out     = spur_data;
            spur_pending = 0;
        end
    endtask

    task automatic send_feature(input logic [15:0] x);
        s_valid = 1'b1;
        s_data  = x;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (acc_seen) break;
        end
        if (!acc_seen) fail_bound("send_feature");
        s_valid = 1'b0;
    endtask

    task automatic wait_pop();
        for (int i = 0; i < 60; i++) begin
            tick();
            if (pop_seen) break;
        end
        if (!pop_seen) fail_bound("wait_pop");
    endtask

    task automatic wait_no_inflight();
        for (int i = 0; i < 60; i++) begin
            if (!inflight) break;
            tick();
        end
        if (inflight) fail_bound("wait_result");
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !inflight) break;
            tick();
        end
        if (exp_q.size() != 0 || inflight) fail_bound("drain");
    endtask

    task automatic model_reset();
        feat_q.delete();
        exp_q.delete();
        inflight      = 0;
        exp_tmo       = 0;
        tmo_at        = -1;
        first_tmo_cyc = -1;
        if (pend_cnt > 0) pend_stale = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0;

        tbl[0] = '{16'h0400, 16'h0400, 32'h0400_0400, 16'h00AD};
        tbl[1] = '{16'h0000, 16'h0000, 32'h0000_0000, 16'h009D};
        tbl[2] = '{16'h0800, 16'h0000, 32'h0000_0800, 16'hFE5D};
        tbl[3] = '{16'h0000, 16'h0400, 32'h0400_0000, 16'h01CD};
        tbl[4] = '{16'hFC00, 16'h0400, 32'h0400_FC00, 16'h02ED};
        tbl[5] = '{16'h7FFF, 16'h8000, 32'h8000_7FFF, 16'hB69D};

        ap_rst       = 1'b1;
        s_valid      = 1'b0;
        s_data       = '0;
        m_ready      = 1'b1;
        core_out     = '0;
        core_out_vld = 1'b0;
        #2;
        check("reset_outputs",
              {s_ready, core_start, core_in, core_in_vld, m_data, m_valid, busy, timeout_err}, 64'd0);
        tick();
        tick();
        ap_rst = 1'b0;
        tick();

        // Fixed vectors
        for (int i = 0; i < 6; i++) begin
            send_feature(tbl[i].x0);
            send_feature(tbl[i].x1);
            wait_pop();
            check($sformatf("tbl%0d_m_data", i), 64'(last_pop), 64'(tbl[i].exp_y));
            check($sformatf("tbl%0d_core_in", i), 64'(core_in), 64'(tbl[i].exp_in));
        end
        drain();

        // Odd trailing feature parks in LO
        send_feature(16'h0123);
        repeat (30) tick();
        check("odd_wait_busy_ready", {busy, s_ready}, 64'b11);
        send_feature(16'h0456);
        drain();

        // Back-pressure: four results fill the FIFO, fifth launch is refused
        m_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            send_feature(16'($urandom));
            send_feature(16'($urandom));
        end
        wait_no_inflight();
        s_valid = 1'b1;
        s_data  = 16'h0BAD;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (acc_seen) check("full_refuses_accept", 64'd1, 64'd0);
        end
        check("full_state", {s_ready, m_valid, busy}, 64'b011);
        s_valid = 1'b0;
        pops0   = pop_total;
        drain();
        check("full_pop_count", 64'(pop_total - pops0), 64'd4);
        for (int p = 0; p < 2; p++) begin
            send_feature(16'($urandom));
            send_feature(16'($urandom));
        end
        drain();
        check("full_total_pops", 64'(pop_total - pops0), 64'd6);

        // Spurious core result while idle
        m_ready      = 1'b0;
        spur_data    = 16'h1234;
        spur_pending = 1;
        repeat (4) tick();
        check("spurious_ignored", {m_valid, busy, m_data}, 64'd0);
        m_ready = 1'b1;

        // Reset in the middle of WAIT with one result buffered
        m_ready = 1'b0;
        send_feature(16'h1111);
        send_feature(16'h2222);
        wait_no_inflight();
        send_feature(16'h3333);
        send_feature(16'h4444);
        repeat (4) tick();
        ap_rst = 1'b1;
        #1;
        check("rst_mid_wait_outputs",
              {s_ready, core_start, core_in, core_in_vld, m_data, m_valid, busy, timeout_err}, 64'd0);
        model_reset();
        tick();
        tick();
        ap_rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (pend_cnt == 0) break;
            tick();
        end
        tick();
        tick();
        check("late_vld_dropped", {m_valid, busy, m_data}, 64'd0);
        m_ready = 1'b1;
        send_feature(16'h0400);
        send_feature(16'h0400);
        wait_pop();
        check("post_reset_m_data", 64'(last_pop), 64'h00AD);
        drain();

`ifdef DNN_TIMEOUT_EN
        // Silent core: watchdog fires and releases the credit
        core_silent = 1;
        send_feature(16'h0400);
        send_feature(16'h0400);
        for (int i = 0; i < TIMEOUT_CYC + 20; i++) begin
            if (first_tmo_cyc >= 0) break;
            tick();
        end
        if (first_tmo_cyc < 0) fail_bound("timeout_flag");
        else check("timeout_delay", 64'(first_tmo_cyc - last_launch), 64'(TIMEOUT_CYC));
        check("timeout_s_ready", 64'(s_ready), 64'd1);
        core_silent = 0;
        repeat (CORE_LAT + 2) tick();
        send_feature(16'h0000);
        send_feature(16'h0000);
        wait_pop();
        check("after_timeout_m_data", 64'(last_pop), 64'h009D);
        drain();
`endif

        // Random traffic
        s_valid = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (acc_seen || !s_valid) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = 16'($urandom);
            end
            m_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        s_valid = 1'b0;
        if (feat_q.size() == 1) send_feature(16'h0001);
        drain();
        tick();
        check("busy_after_drain", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
